// File: rtl/hdc_assoc_search.sv
// Associative-memory search: buffers one query hypervector, walks every class
// frame by frame through the generator, and reports the nearest class by Hamming distance.
module hdc_assoc_search #(
    parameter int FRAME_W   = 64,
    parameter int N_FRAMES  = 3,
    parameter int N_CLASSES = 8,
    parameter int ID_W      = 3,
    parameter int IDX_W     = 2,
    parameter int DIST_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               query_valid,
    output logic               query_ready,
    input  logic [FRAME_W-1:0] query_frame,
    output logic [ID_W-1:0]    class_frame_id,
    output logic [IDX_W-1:0]   class_frame_index,
    input  logic [FRAME_W-1:0] class_vec_in,
    output logic               busy,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [ID_W-1:0]    result_class,
    output logic [DIST_W-1:0]  result_dist
);

    typedef enum logic [1:0] {LOAD, SEARCH, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_FRAME = IDX_W'(N_FRAMES - 1);
    localparam logic [ID_W-1:0]  LAST_CLASS = ID_W'(N_CLASSES - 1);

    state_t                           state_q, state_d;
    logic [N_FRAMES-1:0][FRAME_W-1:0] buf_q;
    logic                             buf_we;
    logic [IDX_W-1:0]                 load_cnt_q, load_cnt_d;
    logic [ID_W-1:0]                  cur_class_q, cur_class_d;
    logic [IDX_W-1:0]                 cur_frame_q, cur_frame_d;
    logic [DIST_W-1:0]                acc_q, acc_d;
    logic [DIST_W-1:0]                best_dist_q, best_dist_d;
    logic [ID_W-1:0]                  best_class_q, best_class_d;
    logic                             res_valid_q, res_valid_d;
    logic [ID_W-1:0]                  res_class_q, res_class_d;
    logic [DIST_W-1:0]                res_dist_q, res_dist_d;

    logic [FRAME_W-1:0] diff;
    logic [DIST_W-1:0]  pop, sum;
    logic               better;

    always_comb begin
        diff = buf_q[cur_frame_q] ^ class_vec_in;
        pop  = '0;
        for (int i = 0; i < FRAME_W; i++) pop = pop + DIST_W'(diff[i]);
        sum    = (cur_frame_q == '0) ? pop : acc_q + pop;
        better = sum < best_dist_q;
    end

    always_comb begin
        state_d      = state_q;
        buf_we       = 1'b0;
        load_cnt_d   = load_cnt_q;
        cur_class_d  = cur_class_q;
        cur_frame_d  = cur_frame_q;
        acc_d        = acc_q;
        best_dist_d  = best_dist_q;
        best_class_d = best_class_q;
        res_valid_d  = res_valid_q;
        res_class_d  = res_class_q;
        res_dist_d   = res_dist_q;
        case (state_q)
            LOAD: begin
                if (query_valid) begin
                    buf_we = 1'b1;
                    if (load_cnt_q == LAST_FRAME) begin
                        state_d      = SEARCH;
                        load_cnt_d   = '0;
                        cur_class_d  = '0;
                        cur_frame_d  = '0;
                        best_dist_d  = '1;
                        best_class_d = '0;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
            end
            SEARCH: begin
                acc_d = sum;
                if (cur_frame_q == LAST_FRAME) begin
                    if (better) begin
                        best_dist_d  = sum;
                        best_class_d = cur_class_q;
                    end
                    cur_frame_d = '0;
                    if (cur_class_q == LAST_CLASS) begin
                        // selects drop back to 0/0 as the search ends
                        state_d     = DONE;
                        cur_class_d = '0;
                        res_valid_d = 1'b1;
                        res_class_d = better ? cur_class_q : best_class_q;
                        res_dist_d  = better ? sum : best_dist_q;
                    end else begin
                        cur_class_d = cur_class_q + 1'b1;
                    end
                end else begin
                    cur_frame_d = cur_frame_q + 1'b1;
                end
            end
            DONE: begin
                if (result_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            load_cnt_q   <= '0;
            cur_class_q  <= '0;
            cur_frame_q  <= '0;
            acc_q        <= '0;
            best_dist_q  <= '1;
            best_class_q <= '0;
            res_valid_q  <= 1'b0;
            res_class_q  <= '0;
            res_dist_q   <= '0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            cur_class_q  <= cur_class_d;
            cur_frame_q  <= cur_frame_d;
            acc_q        <= acc_d;
            best_dist_q  <= best_dist_d;
            best_class_q <= best_class_d;
            res_valid_q  <= res_valid_d;
            res_class_q  <= res_class_d;
            res_dist_q   <= res_dist_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) buf_q <= '0;
        else if (buf_we) buf_q[load_cnt_q] <= query_frame;
    end

    assign query_ready       = (state_q == LOAD);
    assign busy              = (state_q != LOAD);
    assign class_frame_id    = cur_class_q;
    assign class_frame_index = cur_frame_q;
    assign result_valid      = res_valid_q;
    assign result_class      = res_class_q;
    assign result_dist       = res_dist_q;

endmodule

// File: tb/tb_hdc_assoc_search.sv
// Directed bench for hdc_assoc_search with a stub class generator selectable per test.
module tb_hdc_assoc_search;

    localparam logic [63:0] ONES = '1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        query_valid;
    logic        query_ready;
    logic [63:0] query_frame;
    logic [2:0]  class_frame_id;
    logic [1:0]  class_frame_index;
    logic [63:0] class_vec_in;
    logic        busy;
    logic        result_valid;
    logic        result_ready;
    logic [2:0]  result_class;
    logic [7:0]  result_dist;

    int mode;
    int pass_cnt = 0;
    int total_cnt = 0;

    hdc_assoc_search dut (
        .clk(clk), .rst_n(rst_n),
        .query_valid(query_valid), .query_ready(query_ready), .query_frame(query_frame),
        .class_frame_id(class_frame_id), .class_frame_index(class_frame_index),
        .class_vec_in(class_vec_in), .busy(busy),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_class(result_class), .result_dist(result_dist)
    );

    always #5 clk = ~clk;

    // mode 0: ONES >> 8c; mode 1: classes 2,5 all ones, rest zero; mode 2: class 0 all ones, rest zero
    always_comb begin
        case (mode)
            0:       class_vec_in = ONES >> (8 * class_frame_id);
            1:       class_vec_in = (class_frame_id == 3'd2 || class_frame_id == 3'd5) ? ONES : 64'd0;
            default: class_vec_in = (class_frame_id == 3'd0) ? ONES : 64'd0;
        endcase
    end

    typedef struct {
        int          mode;
        logic [63:0] f0, f1, f2;
        int          exp_class;
        int          exp_dist;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_frame(input logic [63:0] f);
        query_valid = 1'b1;
        query_frame = f;
        @(posedge clk); #1;
        query_valid = 1'b0;
        query_frame = 64'hDEAD_BEEF_0BAD_F00D;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!result_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic accept_result();
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
    endtask

    task automatic check_reset_vals(input string name);
        check(name, {query_ready, busy, result_valid, result_class, result_dist,
                     class_frame_id, class_frame_index},
              {1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 2'd0});
    endtask

    initial begin
        int lat;
        logic [2:0] hold_cls;
        logic [7:0] hold_dist;

        vecs[0] = '{0, 64'd0, 64'd0, 64'd0, 7, 24};
        vecs[1] = '{0, ONES, ONES, ONES, 0, 0};
        vecs[2] = '{1, ONES, ONES, ONES, 2, 0};
        vecs[3] = '{2, 64'd0, 64'd0, 64'd0, 1, 0};
        vecs[4] = '{0, ONES, 64'd0, 64'd0, 7, 72};
        vecs[5] = '{0, ONES >> 16, ONES >> 16, ONES >> 16, 2, 0};

        mode = 0;
        rst_n = 1'b0;
        query_valid = 1'b0;
        query_frame = '0;
        result_ready = 1'b0;
        #12;
        check_reset_vals("reset_state");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            mode = vecs[i].mode;
            send_frame(vecs[i].f0);
            send_frame(vecs[i].f1);
            check($sformatf("v%0d_ready_before_last", i), query_ready, 1);
            send_frame(vecs[i].f2);
            check($sformatf("v%0d_busy", i), busy, 1);
            wait_result(lat);
            check($sformatf("v%0d_latency", i), lat, 24);
            check($sformatf("v%0d_class", i), result_class, vecs[i].exp_class);
            check($sformatf("v%0d_dist", i), result_dist, vecs[i].exp_dist);
            check($sformatf("v%0d_sel_idle", i), {class_frame_id, class_frame_index}, 0);
            accept_result();
            check($sformatf("v%0d_back_to_load", i), {query_ready, busy, result_valid}, 3'b100);
        end

        // gapped frames, then a held result with query_valid junk that must be ignored
        mode = 0;
        send_frame(ONES);
        repeat (2) begin @(posedge clk); #1; end
        send_frame(64'd0);
        repeat (3) begin @(posedge clk); #1; end
        send_frame(64'd0);
        wait_result(lat);
        check("gap_latency", lat, 24);
        hold_cls  = result_class;
        hold_dist = result_dist;
        check("gap_class", hold_cls, 7);
        check("gap_dist", hold_dist, 72);
        query_valid = 1'b1;
        query_frame = ONES;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold_c%0d", c), {result_valid, query_ready, busy, result_class, result_dist},
                  {1'b1, 1'b0, 1'b1, 3'd7, 8'd72});
        end
        query_valid = 1'b0;
        accept_result();
        check("post_handshake_ready", {query_ready, busy, result_valid}, 3'b100);
        // any frame wrongly captured during DONE would shift this query
        send_frame(64'd0);
        send_frame(64'd0);
        send_frame(64'd0);
        wait_result(lat);
        check("after_hold_class", result_class, 7);
        check("after_hold_dist", result_dist, 24);
        accept_result();

        // asynchronous reset in the middle of a search
        send_frame(64'd0);
        send_frame(64'd0);
        send_frame(64'd0);
        repeat (10) begin @(posedge clk); #1; end
        check("mid_search_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_reset");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("after_reset_release");
        send_frame(ONES);
        send_frame(ONES);
        send_frame(ONES);
        wait_result(lat);
        check("reset_rerun_latency", lat, 24);
        check("reset_rerun_class", result_class, 0);
        check("reset_rerun_dist", result_dist, 0);
        accept_result();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hdc_assoc_search.md
Name: hdc_assoc_search

Overview:
- Associative-memory search stage that sits directly downstream of the class hypervector generator `class_vec_gen`.
- Buffers one encoded query hypervector, delivered as N_FRAMES frames of FRAME_W bits.
- Sequences frame_id/frame_index into the generator and accumulates the per-class Hamming distance, one frame per cycle.
- Reports the class with the minimum distance over a valid/ready result interface.

Parameters:
- FRAME_W, 64, bits per hypervector frame.
- N_FRAMES, 3, frames per hypervector (D = 192).
- N_CLASSES, 8, number of classes searched.
- ID_W, 3, width of class id; must satisfy 2^ID_W >= N_CLASSES.
- IDX_W, 2, width of frame index; must satisfy 2^IDX_W >= N_FRAMES.
- DIST_W, 8, distance width; must satisfy 2^DIST_W > FRAME_W*N_FRAMES.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- query_valid  in  1  query frame valid.
- query_ready  out  1  block can accept a query frame.
- query_frame  in  FRAME_W  query frame data; frames arrive in order index 0..N_FRAMES-1.
- class_frame_id  out  ID_W  class select to generator.
- class_frame_index  out  IDX_W  frame select to generator.
- class_vec_in  in  FRAME_W  generator output; combinational from the two select outputs.
- busy  out  1  high in SEARCH or DONE.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- result_class  out  ID_W  winning class index.
- result_dist  out  DIST_W  Hamming distance of the winning class.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous, active-low.
- Reset values: state=LOAD, query_ready=1, busy=0, result_valid=0, result_class=0, result_dist=0, class_frame_id=0, class_frame_index=0. All frame/accumulator counters are cleared.
- FSM states are LOAD, SEARCH, DONE.
- LOAD:
  - query_ready=1.
  - A handshake (valid & ready) on an edge stores query_frame into buffer slot load_cnt, then load_cnt increments.
  - The handshake with load_cnt==N_FRAMES-1 moves the FSM to SEARCH, clears load_cnt, sets cur_class=0 and cur_frame=0, sets best_dist to all ones and best_class to 0.
  - query_frame is ignored when query_valid=0.
- SEARCH:
  - query_ready=0.
  - class_frame_id=cur_class and class_frame_index=cur_frame; both are registered, so they are stable for the whole cycle.
  - pop = popcount(buf[cur_frame] XOR class_vec_in), computed in the same cycle.
  - sum = pop when cur_frame==0, otherwise acc+pop. acc is registered to sum each SEARCH cycle.
  - When cur_frame==N_FRAMES-1: if sum < best_dist (strict), update best_dist=sum and best_class=cur_class. Ties keep the lower class index.
  - Counters: cur_frame wraps to 0 and cur_class increments.
  - Leaving SEARCH: after the cycle with cur_class==N_CLASSES-1 and cur_frame==N_FRAMES-1, go to DONE. On that edge, load result_class and result_dist from the final best (including this last comparison) and set result_valid=1.
- Latency:
  - If the last query frame is accepted on edge k, SEARCH occupies edges k+1..k+N_CLASSES*N_FRAMES.
  - result_valid rises on edge k+N_CLASSES*N_FRAMES (24 edges with the defaults).
  - Selects return to 0/0 outside SEARCH.
- DONE:
  - result_valid=1 and result_class/result_dist are held stable until result_ready=1.
  - The handshake edge clears result_valid and returns to LOAD.
  - query_ready is 0 throughout DONE; no overlap of a new query with a pending result.
- Width rules:
  - popcount is at most FRAME_W; acc is at most FRAME_W*N_FRAMES < 2^DIST_W, so no saturation is required.
  - The buffer index never exceeds N_FRAMES-1.
- Reset mid-operation: asserting rst_n in any state immediately forces the reset values. A partial query or partial search is discarded.
- result_ready while result_valid=0 has no effect. query_valid outside LOAD has no effect.

Test Plan:
Bench uses a stub generator where class c, every frame, equals {FRAME_W{1}} >> (8*c).
- Query all-zeros (3 frames) -> per-class distance 3*(64-8c); result_class=7, result_dist=24, result_valid rises exactly 24 edges after the third handshake.
- Query all-ones -> result_class=0, result_dist=0; class 0 distance is 0, class 7 distance is 168.
- Stub with classes 2 and 5 both identical to the query -> result_class=2, result_dist=0 (tie keeps lower index).
- query_valid toggling with gaps between frames, plus result_ready held low 10 cycles after result_valid -> frames are stored in order, result is stable for all 10 cycles, query_ready=0 and busy=1 until the result handshake, then query_ready=1 on the next cycle.
- rst_n pulsed low during search cycle 10 -> outputs return to reset values asynchronously; a following all-ones query yields result_class=0, result_dist=0.
- Stub with class 0 all-ones and the rest all-zeros, query all-zeros -> class 0 distance=192 (max, no overflow), result_class=1, result_dist=0.
